cell_bist_stim4: RTL and testbench
==================================

# cell_bist_stim4

Built-in self-test driver/compactor for 4-input complex cells in the mcu9t5v0 library (aoi211, oai211 and similar). It drives every input combination onto A1/A2/B/C and captures the cell's ZN response on each pattern. ZN is compacted into a 16-bit MISR signature, which is compared against a golden value. It sits in the cell-characterisation test harness, wrapped around a single device-under-test cell instance.

## Interface
- SETTLE_CYC, 2: cycles each vector is held before ZN is sampled; legal 1..15.
- SEED, 16'h0000: MISR value loaded at reset and on START accept.
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  run request; accepted only in IDLE.
- GOLD  input  16  expected signature; sampled when the DONE state is entered.
- ZN  input  1  response from the DUT cell.
- A1, A2, B, C  output  1 each  stimulus to the DUT. Vector bit 3 = A1, bit 0 = C.
- BUSY  output  1  high from START accept until the DONE cycle (exclusive).
- DONE  output  1  one-cycle pulse at end of run.
- SIG  output  16  MISR state.
- PASS  output  1  registered result of SIG==GOLD.

## Operation
- States: IDLE, SETTLE, SAMPLE, FIN.
- IDLE, START=1: go to SETTLE.
  - Pattern counter cnt=0, settle counter=0, SIG=SEED, PASS=0, BUSY=1.
- SETTLE: holds for SETTLE_CYC cycles, then goes to SAMPLE.
- SAMPLE (1 cycle):
  - MISR update: fb = SIG[15]^SIG[13]^SIG[12]^SIG[10]; SIG <= {SIG[14:0], fb^ZN}.
  - If cnt==15, go to FIN; else cnt++ and go to SETTLE.
- FIN (1 cycle): DONE=1, BUSY=0, PASS <= (SIG==GOLD); then IDLE.
- Vector = cnt in binary order (see Configuration). Outputs are registered and change only on the first SETTLE cycle of each pattern.
- A1..C hold the last vector through FIN and IDLE, until the next START.
- START while not in IDLE: ignored, including in FIN.
- PASS and SIG hold after FIN until the next START accept.
- Reset values: A1=A2=B=C=0, BUSY=0, DONE=0, SIG=SEED, PASS=0, state IDLE, counters 0.
- RST mid-run: immediate return to reset values, no partial DONE.

## Timing
- START sampled at edge 0. Pattern k is driven from cycle 1+k·(SETTLE_CYC+1).
- ZN is captured at the final edge of the SAMPLE cycle.
- DONE at cycle 16·(SETTLE_CYC+1)+1, i.e. cycle 49 for the default SETTLE_CYC.
- SIG is final and PASS valid from that cycle onwards.
- Back-to-back runs: earliest next START accept is the cycle after DONE.

## Configuration
- CELL_BIST_GRAY_EN defined: vector = cnt ^ (cnt>>1) (Gray order, one input toggles per step). Sequence 0,1,3,2,6,7,5,4,12,…,8.
- CELL_BIST_GRAY_EN undefined: vector = cnt (binary order 0..15).
- Signature and timing rules are otherwise identical.

## Structure
- Package cell_bist_pkg holds:
  - state enum;
  - MISR width (16);
  - tap mask 16'hB400 (bits 15,13,12,10);
  - vector width (4).
- Sub-module cell_bist_misr: 16-bit single-input MISR with load (SEED) and enable (SAMPLE).
- The FSM, counters and the compare stay in the top level.

## Test plan
- Reset: assert RST mid-idle → A1..C=0, BUSY=0, DONE=0, PASS=0, SIG=16'h0000.
- ZN tied 0, GOLD=16'h0000, START at cycle 0 → BUSY cycles 1–48, DONE pulse at cycle 49, SIG=16'h0000, PASS=1.
- ZN tied 1, GOLD=16'h0000 → SIG=16'hFFE4, PASS=0. Rerun with GOLD=16'hFFE4 → PASS=1.
- START pulsed at cycles 5 and 30 during a run → ignored; DONE still at cycle 49, exactly once.
- RST asserted at cycle 20 → outputs at reset values immediately. START at cycle 25 → DONE at cycle 74.
- Vector sequence check, sampled once per pattern:
  - with CELL_BIST_GRAY_EN: {A1,A2,B,C} = 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8, each step Hamming distance 1;
  - without it: 0..15.

Source files
------------

// File: rtl/cell_bist_pkg.sv
// Shared definitions for the 4-input complex-cell BIST driver/compactor.
// Holds the FSM state encoding, MISR geometry and the stimulus ordering.
// Optional feature macro: CELL_BIST_GRAY_EN (Gray-ordered stimulus vectors).
package cell_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_FIN
    } state_t;

    localparam int unsigned MISR_W    = 16;
    localparam logic [MISR_W-1:0] MISR_TAPS = 16'hB400;  // bits 15,13,12,10
    localparam int unsigned VEC_W     = 4;

    // Maps the pattern counter onto the {A1,A2,B,C} stimulus vector.
    function automatic logic [VEC_W-1:0] vec_of(input logic [VEC_W-1:0] cnt);
`ifdef CELL_BIST_GRAY_EN
        return cnt ^ (cnt >> 1);
`else
        return cnt;
`endif
    endfunction

endpackage

// File: rtl/cell_bist_misr.sv
// 16-bit single-input MISR used to compact the cell's ZN response.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (loads SEED)
//   load      - synchronous reload with SEED
//   en        - shift in din this cycle
//   din       - serial response bit
//   sig       - current signature
//   sig_next  - signature after an enabled shift (combinational)
module cell_bist_misr
    import cell_bist_pkg::*;
#(
    parameter logic [MISR_W-1:0] SEED = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              en,
    input  logic              din,
    output logic [MISR_W-1:0] sig,
    output logic [MISR_W-1:0] sig_next
);

    logic fb;

    assign fb       = ^(sig & MISR_TAPS);
    assign sig_next = {sig[MISR_W-2:0], fb ^ din};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= SEED;
        end else if (load) begin
            sig <= SEED;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/cell_bist_stim4.sv
// BIST driver/compactor for one 4-input complex cell (aoi211, oai211, ...).
// Walks all 16 input combinations onto A1/A2/B/C, holds each for SETTLE_CYC
// cycles, compacts ZN into a 16-bit MISR and compares against GOLD.
// Optional feature macro: CELL_BIST_GRAY_EN (Gray-ordered vectors).
// Ports:
//   CLK, RST       - clock, asynchronous active-high reset
//   START          - run request, honoured only in IDLE
//   GOLD           - expected signature, sampled on entry to FIN
//   ZN             - response of the cell under test
//   A1, A2, B, C   - stimulus to the cell (vector bit 3 = A1, bit 0 = C)
//   BUSY           - run in progress
//   DONE           - one-cycle end-of-run pulse
//   SIG            - MISR signature
//   PASS           - registered SIG==GOLD result
module cell_bist_stim4
    import cell_bist_pkg::*;
#(
    parameter int unsigned       SETTLE_CYC = 2,
    parameter logic [MISR_W-1:0] SEED       = 16'h0000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [MISR_W-1:0] GOLD,
    input  logic              ZN,
    output logic              A1,
    output logic              A2,
    output logic              B,
    output logic              C,
    output logic              BUSY,
    output logic              DONE,
    output logic [MISR_W-1:0] SIG,
    output logic              PASS
);

    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [VEC_W-1:0] CNT_LAST    = '1;

    state_t            state_q, state_d;
    logic [VEC_W-1:0]  cnt_q;
    logic [3:0]        scnt_q;
    logic [VEC_W-1:0]  vec_q;
    logic              busy_q, done_q, pass_q;
    logic              misr_load, misr_en;
    logic [MISR_W-1:0] misr_next;

    cell_bist_misr #(.SEED(SEED)) u_misr (
        .clk      (CLK),
        .rst      (RST),
        .load     (misr_load),
        .en       (misr_en),
        .din      (ZN),
        .sig      (SIG),
        .sig_next (misr_next)
    );

    always_comb begin
        state_d   = state_q;
        misr_load = 1'b0;
        misr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d   = ST_SETTLE;
                    misr_load = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (scnt_q == SETTLE_LAST) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                misr_en = 1'b1;
                state_d = (cnt_q == CNT_LAST) ? ST_FIN : ST_SETTLE;
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Vector, BUSY, DONE and PASS are updated on the edge that enters the
    // next state, so each settles exactly on the first cycle of that state.
    // PASS compares the post-shift signature, valid from the DONE cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            scnt_q  <= '0;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        cnt_q  <= '0;
                        scnt_q <= '0;
                        vec_q  <= vec_of('0);
                        busy_q <= 1'b1;
                        pass_q <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    scnt_q <= (scnt_q == SETTLE_LAST) ? '0 : scnt_q + 4'd1;
                end
                ST_SAMPLE: begin
                    if (cnt_q == CNT_LAST) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        pass_q <= (misr_next == GOLD);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        vec_q <= vec_of(cnt_q + 1'b1);
                    end
                end
                ST_FIN: begin
                    done_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign {A1, A2, B, C} = vec_q;
    assign BUSY = busy_q;
    assign DONE = done_q;
    assign PASS = pass_q;

endmodule

// File: tb/tb_cell_bist_stim4.sv
module tb_cell_bist_stim4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [15:0] GOLD = '0;
    logic        ZN;
    logic        A1, A2, B, C;
    logic        BUSY, DONE, PASS;
    logic [15:0] SIG;

    int zn_mode = 0;   // 0: tied low, 1: tied high, 2: aoi211 model
    int nchk = 0;
    int nbad = 0;

    logic [3:0]  vq[$];   // expected vectors, one per pattern
    logic [16:0] rq[$];   // expected {PASS, SIG} at DONE

    always #5 CLK = ~CLK;

    assign ZN = (zn_mode == 0) ? 1'b0 :
                (zn_mode == 1) ? 1'b1 : ~((A1 & A2) | B | C);

    cell_bist_stim4 dut (
        .CLK(CLK), .RST(RST), .START(START), .GOLD(GOLD), .ZN(ZN),
        .A1(A1), .A2(A2), .B(B), .C(C),
        .BUSY(BUSY), .DONE(DONE), .SIG(SIG), .PASS(PASS)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_vec(input int k);
        logic [3:0] gray_tab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                      4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
`ifdef CELL_BIST_GRAY_EN
        return gray_tab[k];
`else
        return 4'(k);
`endif
    endfunction

    // Reference signature for the aoi211 response, from the MISR equation.
    function automatic logic [15:0] aoi_sig();
        logic [15:0] s;
        logic [3:0]  v;
        logic        z, fb;
        s = 16'h0000;
        for (int k = 0; k < 16; k++) begin
            v  = exp_vec(k);
            z  = ~((v[3] & v[2]) | v[1] | v[0]);
            fb = s[15] ^ s[13] ^ s[12] ^ s[10];
            s  = {s[14:0], fb ^ z};
        end
        return s;
    endfunction

    // Monitor: checks vectors once per pattern and the result at each DONE.
    int   rel = 0;
    logic busy_prev = 1'b0;
    always @(negedge CLK) begin
        if (RST) begin
            busy_prev = 1'b0;
        end else begin
            if (BUSY && !busy_prev) rel = 0;
            else if (BUSY) rel++;
            if (BUSY && (rel % 3 == 0)) begin
                if (vq.size() == 0) check("vec_unexpected", 1, 0);
                else check($sformatf("vec_rel%0d", rel), {28'd0, A1, A2, B, C}, {28'd0, vq.pop_front()});
            end
            if (DONE) begin
                if (rq.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    logic [16:0] e;
                    e = rq.pop_front();
                    check("done_sig", {16'd0, SIG}, {16'd0, e[15:0]});
                    check("done_pass", {31'd0, PASS}, {31'd0, e[16]});
                    check("done_cycle", rel, 47);
                    check("busy_at_done", {31'd0, BUSY}, 0);
                end
            end
            busy_prev = BUSY;
        end
    end

    // Called at a negedge; START is sampled by the following rising edge.
    task automatic start_run(input int mode, input logic [15:0] gold, input logic [15:0] exp_sig);
        zn_mode = mode;
        GOLD    = gold;
        for (int k = 0; k < 16; k++) vq.push_back(exp_vec(k));
        rq.push_back({(exp_sig == gold), exp_sig});
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!DONE && t < 200) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 200) check("done_timeout", 1, 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_vec"}, {28'd0, A1, A2, B, C}, 0);
        check({tag, "_busy"}, {31'd0, BUSY}, 0);
        check({tag, "_done"}, {31'd0, DONE}, 0);
        check({tag, "_pass"}, {31'd0, PASS}, 0);
        check({tag, "_sig"}, {16'd0, SIG}, 0);
    endtask

    initial begin
        logic [15:0] aoi;
        aoi = aoi_sig();
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        // Reset asserted while idle.
        #2 RST = 1'b1;
        #1 check_reset("rst_idle");
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // ZN tied low: signature stays at the zero seed.
        start_run(0, 16'h0000, 16'h0000);
        wait_done();
        repeat (3) @(negedge CLK);
        check("pass_hold", {31'd0, PASS}, 1);
        check("sig_hold", {16'd0, SIG}, 0);

        // ZN tied high with stray START pulses mid-run.
        start_run(1, 16'h0000, 16'hFFE4);
        repeat (3) @(negedge CLK);
        START = 1'b1; @(negedge CLK); START = 1'b0;
        repeat (24) @(negedge CLK);
        START = 1'b1; @(negedge CLK); START = 1'b0;
        wait_done();
        // START presented to the FIN edge must be ignored.
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        check("start_in_fin", {31'd0, BUSY}, 0);
        @(negedge CLK);
        check("start_in_fin2", {31'd0, BUSY}, 0);

        // Matching golden value, then a back-to-back aoi211 run.
        start_run(1, 16'hFFE4, 16'hFFE4);
        wait_done();
        @(negedge CLK);
        start_run(2, aoi, aoi);
        wait_done();
        @(negedge CLK);

        // Reset mid-run, then a fresh run.
        start_run(1, 16'hFFE4, 16'hFFE4);
        repeat (18) @(negedge CLK);
        #2 RST = 1'b1;
        vq.delete();
        rq.delete();
        #1 check_reset("rst_run");
        @(negedge CLK);
        RST = 1'b0;
        repeat (4) @(negedge CLK);
        start_run(0, 16'h0000, 16'h0000);
        wait_done();

        repeat (4) @(negedge CLK);
        check("vq_empty", vq.size(), 0);
        check("rq_empty", rq.size(), 0);
        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

endmodule
